// File: rtl/alu_operand_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_debouncer_if
// Brief    : Bundle of raw switch inputs and debounced ALU-facing outputs
//            for the Hack ALU operand debouncer.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_operand_debouncer_if #(
    parameter int DATA_W = 4,
    parameter int CTRL_W = 6
);
    logic [DATA_W-1:0] sw_x_raw;
    logic [DATA_W-1:0] sw_y_raw;
    logic [CTRL_W-1:0] ctrl_raw;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic [CTRL_W-1:0] control;
    logic              changed;
    logic [2:0]        changed_src;
    logic              settling;

    // Switch side: drives raw switches, observes the debounced results
    modport master (
        output sw_x_raw, sw_y_raw, ctrl_raw,
        input  x, y, control, changed, changed_src, settling
    );

    // Debouncer side
    modport slave (
        input  sw_x_raw, sw_y_raw, ctrl_raw,
        output x, y, control, changed, changed_src, settling
    );
endinterface
`default_nettype wire

// File: rtl/alu_operand_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_debouncer
// Brief    : Synchronises and debounces the x, y and control switch groups
//            of the Hack ALU independently, and raises a one-cycle change
//            strobe naming the groups that committed a new value.
// Revision : 1.0 - initial release
// ============================================================================

// One switch group: synchroniser chain plus IDLE/SETTLE debounce FSM.
module alu_operand_debouncer_group #(
    parameter int W               = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] raw,
    output logic [W-1:0] out,
    output logic         commit_next,  // this edge commits a new value
    output logic         settle_next   // FSM will be in SETTLE after this edge
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    logic [W-1:0]     r_sync [SYNC_STAGES];
    logic [W-1:0]     w_s;
    state_t           r_state, w_state_nxt;
    logic [W-1:0]     r_cand, w_cand_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [W-1:0]     r_out, w_out_nxt;
    logic             w_commit;

    // Multi-stage synchroniser on every raw bit
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // FSM, candidate, counter and committed-value registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cand  <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
        end
    end

    // Debounce decision: a candidate must hold for DEBOUNCE_CYCLES cycles;
    // a bounce back to the committed value abandons it, a different value
    // restarts the window. The count stops at CNT_LAST, so it never wraps.
    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_s != r_out) begin
                    w_cand_nxt  = w_s;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (w_s != r_cand) begin
                    if (w_s == r_out) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cand_nxt = w_s;
                        w_cnt_nxt  = '0;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_out_nxt   = r_cand;
                    w_state_nxt = IDLE;
                    w_commit    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign out         = r_out;
    assign commit_next = w_commit;
    assign settle_next = (w_state_nxt == SETTLE);
endmodule

module alu_operand_debouncer #(
    parameter int DATA_W          = 4,
    parameter int CTRL_W          = 6,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_operand_debouncer_if.slave bus
);
    logic [2:0] w_commit;
    logic [2:0] w_settle;
    logic       r_changed;
    logic [2:0] r_changed_src;
    logic       r_settling;

    alu_operand_debouncer_group #(
        .W(DATA_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)
    ) u_grp_x (
        .clk(clk), .rst(rst), .raw(bus.sw_x_raw), .out(bus.x),
        .commit_next(w_commit[0]), .settle_next(w_settle[0])
    );

    alu_operand_debouncer_group #(
        .W(DATA_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)
    ) u_grp_y (
        .clk(clk), .rst(rst), .raw(bus.sw_y_raw), .out(bus.y),
        .commit_next(w_commit[1]), .settle_next(w_settle[1])
    );

    alu_operand_debouncer_group #(
        .W(CTRL_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)
    ) u_grp_ctrl (
        .clk(clk), .rst(rst), .raw(bus.ctrl_raw), .out(bus.control),
        .commit_next(w_commit[2]), .settle_next(w_settle[2])
    );

    // Strobe and status registered on the same edge as the group outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_changed     <= 1'b0;
            r_changed_src <= '0;
            r_settling    <= 1'b0;
        end else begin
            r_changed     <= |w_commit;
            r_changed_src <= w_commit;
            r_settling    <= |w_settle;
        end
    end

    assign bus.changed     = r_changed;
    assign bus.changed_src = r_changed_src;
    assign bus.settling    = r_settling;
endmodule
`default_nettype wire

// File: tb/tb_alu_operand_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_debouncer
// Brief    : Self-checking bench for alu_operand_debouncer with
//            DEBOUNCE_CYCLES=4, SYNC_STAGES=2 (commit at edge 7).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_debouncer;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    alu_operand_debouncer_if #(.DATA_W(4), .CTRL_W(6)) bus ();

    alu_operand_debouncer #(
        .DATA_W(4), .CTRL_W(6), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] xr;
        logic [3:0] yr;
        logic [5:0] cr;
        logic [3:0] ex;
        logic [3:0] ey;
        logic [5:0] ec;
        logic [2:0] src;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [3:0] px, py;
    logic [5:0] pc;
    int         pulses;
    int         pulse_edge;
    logic [2:0] pulse_src;
    logic       seen_settle;
    logic       saw_y3;

    initial begin
        // Hand-computed vectors: each commits at edge 7 after being applied
        vecs[0] = '{4'h0, 4'hF, 6'h3F, 4'h0, 4'hF, 6'h3F, 3'b001};
        vecs[1] = '{4'hA, 4'hF, 6'h3F, 4'hA, 4'hF, 6'h3F, 3'b001};
        vecs[2] = '{4'h2, 4'hF, 6'h2A, 4'h2, 4'hF, 6'h2A, 3'b101};
        vecs[3] = '{4'h2, 4'h0, 6'h2A, 4'h2, 4'h0, 6'h2A, 3'b010};
        vecs[4] = '{4'h7, 4'h5, 6'h00, 4'h7, 4'h5, 6'h00, 3'b111};
        vecs[5] = '{4'h7, 4'h5, 6'h15, 4'h7, 4'h5, 6'h15, 3'b100};
        vecs[6] = '{4'h0, 4'h0, 6'h00, 4'h0, 4'h0, 6'h00, 3'b111};

        // ---- Reset with all switches high ----
        rst = 1'b1;
        bus.sw_x_raw = 4'hF; bus.sw_y_raw = 4'hF; bus.ctrl_raw = 6'h3F;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("rst_x", 32'(bus.x), 0);
            chk("rst_y", 32'(bus.y), 0);
            chk("rst_ctrl", 32'(bus.control), 0);
            chk("rst_changed", 32'(bus.changed), 0);
            chk("rst_src", 32'(bus.changed_src), 0);
            chk("rst_settling", 32'(bus.settling), 0);
        end
        rst = 1'b0;
        pulses = 0;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (bus.changed) pulses++;
        end
        chk("init_no_early_pulse", 32'(pulses), 0);
        chk("init_x_e6", 32'(bus.x), 0);
        step();
        chk("init_x_e7", 32'(bus.x), 32'hF);
        chk("init_y_e7", 32'(bus.y), 32'hF);
        chk("init_ctrl_e7", 32'(bus.control), 32'h3F);
        chk("init_changed_e7", 32'(bus.changed), 1);
        chk("init_src_e7", 32'(bus.changed_src), 32'b111);
        step();
        chk("init_changed_e8", 32'(bus.changed), 0);
        chk("init_src_e8", 32'(bus.changed_src), 0);
        px = 4'hF; py = 4'hF; pc = 6'h3F;

        // ---- Table-driven clean commits ----
        for (int i = 0; i < NV; i++) begin
            bus.sw_x_raw = vecs[i].xr;
            bus.sw_y_raw = vecs[i].yr;
            bus.ctrl_raw = vecs[i].cr;
            pulses = 0;
            for (int e = 1; e <= 6; e++) begin
                step();
                if (bus.changed) pulses++;
            end
            chk($sformatf("v%0d_no_early_pulse", i), 32'(pulses), 0);
            chk($sformatf("v%0d_x_hold", i), 32'(bus.x), 32'(px));
            chk($sformatf("v%0d_y_hold", i), 32'(bus.y), 32'(py));
            chk($sformatf("v%0d_ctrl_hold", i), 32'(bus.control), 32'(pc));
            step();
            chk($sformatf("v%0d_x", i), 32'(bus.x), 32'(vecs[i].ex));
            chk($sformatf("v%0d_y", i), 32'(bus.y), 32'(vecs[i].ey));
            chk($sformatf("v%0d_ctrl", i), 32'(bus.control), 32'(vecs[i].ec));
            chk($sformatf("v%0d_changed", i), 32'(bus.changed), 1);
            chk($sformatf("v%0d_src", i), 32'(bus.changed_src), 32'(vecs[i].src));
            step();
            chk($sformatf("v%0d_changed_drop", i), 32'(bus.changed), 0);
            chk($sformatf("v%0d_src_drop", i), 32'(bus.changed_src), 0);
            px = vecs[i].ex; py = vecs[i].ey; pc = vecs[i].ec;
        end

        // ---- Bounce rejection on x (period 4 < window) ----
        pulses = 0;
        seen_settle = 1'b0;
        for (int c = 0; c < 40; c++) begin
            bus.sw_x_raw = ((c / 2) % 2 == 0) ? 4'h5 : 4'h0;
            step();
            if (bus.changed) pulses++;
            if (bus.settling) seen_settle = 1'b1;
        end
        bus.sw_x_raw = 4'h0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (bus.changed) pulses++;
        end
        chk("bounce_no_pulse", 32'(pulses), 0);
        chk("bounce_settling_seen", 32'(seen_settle), 1);
        chk("bounce_settling_low", 32'(bus.settling), 0);
        chk("bounce_x_held", 32'(bus.x), 0);

        // ---- Window restart on y: 0 -> 3 -> 6 ----
        bus.sw_y_raw = 4'h3;
        pulses = 0; pulse_edge = 0; pulse_src = '0; saw_y3 = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            if (e == 3) bus.sw_y_raw = 4'h6;
            step();
            if (bus.y == 4'h3) saw_y3 = 1'b1;
            if (bus.changed) begin
                pulses++;
                pulse_edge = e;
                pulse_src  = bus.changed_src;
            end
        end
        chk("restart_pulses", 32'(pulses), 1);
        chk("restart_edge", 32'(pulse_edge), 9);
        chk("restart_src", 32'(pulse_src), 32'b010);
        chk("restart_no_y3", 32'(saw_y3), 0);
        chk("restart_y", 32'(bus.y), 32'h6);

        // ---- Back-to-back commits on consecutive cycles ----
        bus.sw_x_raw = 4'h3;
        step();
        bus.sw_y_raw = 4'h4;
        pulses = 0;
        for (int e = 2; e <= 6; e++) begin
            step();
            if (bus.changed) pulses++;
        end
        chk("b2b_no_early_pulse", 32'(pulses), 0);
        step();
        chk("b2b_e7_changed", 32'(bus.changed), 1);
        chk("b2b_e7_src", 32'(bus.changed_src), 32'b001);
        chk("b2b_e7_x", 32'(bus.x), 32'h3);
        chk("b2b_e7_y", 32'(bus.y), 32'h6);
        step();
        chk("b2b_e8_changed", 32'(bus.changed), 1);
        chk("b2b_e8_src", 32'(bus.changed_src), 32'b010);
        chk("b2b_e8_y", 32'(bus.y), 32'h4);
        step();
        chk("b2b_e9_changed", 32'(bus.changed), 0);

        // ---- Reset mid-settle: y -> 9, rst at edge 4 ----
        bus.sw_y_raw = 4'h9;
        pulses = 0;
        for (int e = 1; e <= 3; e++) begin
            step();
            if (bus.changed) pulses++;
        end
        chk("midrst_pre_pulse", 32'(pulses), 0);
        chk("midrst_pre_y", 32'(bus.y), 32'h4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_y", 32'(bus.y), 0);
        chk("midrst_x", 32'(bus.x), 0);
        chk("midrst_changed", 32'(bus.changed), 0);
        chk("midrst_settling", 32'(bus.settling), 0);
        pulses = 0;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (bus.changed) pulses++;
        end
        chk("postrst_no_early_pulse", 32'(pulses), 0);
        chk("postrst_y_e6", 32'(bus.y), 0);
        step();
        chk("postrst_y_e7", 32'(bus.y), 32'h9);
        chk("postrst_x_e7", 32'(bus.x), 32'h3);
        chk("postrst_ctrl_e7", 32'(bus.control), 0);
        chk("postrst_changed", 32'(bus.changed), 1);
        chk("postrst_src", 32'(bus.changed_src), 32'b011);
        step();
        chk("postrst_changed_drop", 32'(bus.changed), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
